ysyx_23060072_regfile_sb: RTL

Receiving end of the writeback interface. It holds the 16 × 32-bit RV32E integer register file and takes `wb_flag/wb_addr/wb_data` from the WB stage each cycle. It serves two combinational read ports to the ID stage, with same-cycle WB→ID bypass. A per-register pending-write scoreboard reserves `rd` when an instruction issues from ID to EX and releases it on writeback. From that scoreboard it generates the ID stall for RAW hazards.

---
 rtl/ysyx_23060072_regfile_sb_pkg.sv | 22 ++
 rtl/ysyx_23060072_regfile_sb_scoreboard.sv | 85 ++++++++
 rtl/ysyx_23060072_regfile_sb.sv | 95 +++++++++
 3 files changed

// File: rtl/ysyx_23060072_regfile_sb_pkg.sv
// Shared constants, types and address helpers for the RV32E register file
// and its pending-write scoreboard.
package ysyx_23060072_regfile_sb_pkg;

  localparam int REG_NUM = 16;  // architectural registers in RV32E
  localparam int REG_AW  = 4;   // bits needed to index REG_NUM entries
  localparam int ADDR_W  = 5;   // register address width on the ports
  localparam int XLEN    = 32;

  localparam logic [ADDR_W-1:0] X0 = '0;

  // Largest value a pending counter of the given width can hold.
  function automatic int pend_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  // True for x1..x15; x0 and anything with bit 4 set are not real targets.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return !a[ADDR_W-1] && (a != X0);
  endfunction

endpackage

// File: rtl/ysyx_23060072_regfile_sb_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register, bumped when
// an instruction writing that register issues and released on its writeback.
module ysyx_23060072_regfile_sb_scoreboard
  import ysyx_23060072_regfile_sb_pkg::*;
#(
  parameter int NREG  = REG_NUM,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  input  logic              issue_we_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic              wb_flag_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              rs1_one_o,
  output logic              rs1_busy_o,
  output logic              rs2_one_o,
  output logic              rs2_busy_o,
  output logic              rd_full_o
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_max(CNT_W));

  logic [CNT_W-1:0] pend_q [NREG];
  logic [CNT_W-1:0] pend_d [NREG];
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  dec;
  logic [NREG-1:0]  empty;

  // Reserve/release events per register and the resulting next count.
  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc[r]    = 1'b0;
      dec[r]    = 1'b0;
      if (r != 0) begin
        inc[r] = issue_i && issue_we_i && (issue_rd_i == ADDR_W'(r));
        dec[r] = wb_flag_i && (wb_addr_i == ADDR_W'(r));
      end
      empty[r]  = (pend_q[r] == '0);
      pend_d[r] = pend_q[r];
      if (inc[r] && !dec[r] && (pend_q[r] != PEND_MAX)) begin
        pend_d[r] = pend_q[r] + 1'b1;
      end else if (dec[r] && !inc[r] && !empty[r]) begin
        pend_d[r] = pend_q[r] - 1'b1;
      end
    end
  end

  // Counters clear on reset, otherwise take the next-state value.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
    end
  end

  // A writeback with no outstanding reservation means the pipeline lost track.
  always @(posedge clk) begin
    if (!rst) begin
      assert ((dec & ~inc & empty) == '0)
        else $error("scoreboard: writeback to a register with no pending write");
    end
  end

  logic [CNT_W-1:0] rs1_pend;
  logic [CNT_W-1:0] rs2_pend;
  logic [CNT_W-1:0] rd_pend;

  assign rs1_pend   = addr_ok(rs1_addr_i) ? pend_q[rs1_addr_i[REG_AW-1:0]] : '0;
  assign rs2_pend   = addr_ok(rs2_addr_i) ? pend_q[rs2_addr_i[REG_AW-1:0]] : '0;
  assign rd_pend    = addr_ok(issue_rd_i) ? pend_q[issue_rd_i[REG_AW-1:0]] : '0;

  assign rs1_busy_o = (rs1_pend != '0);
  assign rs1_one_o  = (rs1_pend == CNT_W'(1));
  assign rs2_busy_o = (rs2_pend != '0);
  assign rs2_one_o  = (rs2_pend == CNT_W'(1));
  assign rd_full_o  = (rd_pend == PEND_MAX);

endmodule

// File: rtl/ysyx_23060072_regfile_sb.sv
// RV32E register file with WB->ID bypass, pending-write scoreboard and the
// RAW / WAW-overflow stall for the ID stage.
module ysyx_23060072_regfile_sb
  import ysyx_23060072_regfile_sb_pkg::*;
#(
  parameter int NREG  = REG_NUM,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_flag_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic              issue_i,
  input  logic              issue_we_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  output logic              stall_o,
  output logic              addr_err_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wb_we;

  assign wb_we = wb_flag_i && addr_ok(wb_addr_i);

  // Architectural write port; x0 and illegal addresses never reach the array.
  // NOTE: the array is cleared on reset so every register reads 0 straight after reset; it therefore cannot map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (wb_we) begin
      regs_q[wb_addr_i[REG_AW-1:0]] <= wb_data_i;
    end
  end

  // Read ports with same-cycle writeback bypass; x0 and illegal reads give 0.
  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (addr_ok(rs1_addr_i)) begin
      rs1_data_o = (wb_we && (wb_addr_i == rs1_addr_i)) ? wb_data_i
                                                        : regs_q[rs1_addr_i[REG_AW-1:0]];
    end
    if (addr_ok(rs2_addr_i)) begin
      rs2_data_o = (wb_we && (wb_addr_i == rs2_addr_i)) ? wb_data_i
                                                        : regs_q[rs2_addr_i[REG_AW-1:0]];
    end
  end

  logic rs1_one, rs1_busy, rs2_one, rs2_busy, rd_full;

  ysyx_23060072_regfile_sb_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (issue_i),
    .issue_we_i (issue_we_i),
    .issue_rd_i (issue_rd_i),
    .wb_flag_i  (wb_flag_i),
    .wb_addr_i  (wb_addr_i),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_one_o  (rs1_one),
    .rs1_busy_o (rs1_busy),
    .rs2_one_o  (rs2_one),
    .rs2_busy_o (rs2_busy),
    .rd_full_o  (rd_full)
  );

  // A last outstanding write being retired this cycle is covered by the bypass.
  logic haz_rs1, haz_rs2, haz_waw;

  assign haz_rs1 = rs1_used_i && rs1_busy &&
                   !(rs1_one && wb_flag_i && (wb_addr_i == rs1_addr_i));
  assign haz_rs2 = rs2_used_i && rs2_busy &&
                   !(rs2_one && wb_flag_i && (wb_addr_i == rs2_addr_i));
  assign haz_waw = issue_we_i && rd_full;

  // Independent of issue_i so upstream can gate issue on it without a loop.
  assign stall_o = haz_rs1 || haz_rs2 || haz_waw;

  assign addr_err_o = (rs1_used_i && rs1_addr_i[ADDR_W-1]) ||
                      (rs2_used_i && rs2_addr_i[ADDR_W-1]) ||
                      (issue_i && issue_we_i && issue_rd_i[ADDR_W-1]) ||
                      (wb_flag_i && wb_addr_i[ADDR_W-1]);

endmodule
